// File: rtl/factorial_pkg.sv
// Shared types and default widths for the sequential factorial engine.
package factorial_pkg;

    localparam int DEF_IN_W  = 10;
    localparam int DEF_OUT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/factorial_seq_if.sv
// Request/response bundle for factorial_seq, plus the FSM state for observation.
// Handshake: start is a one-cycle request taken only when the engine is idle and
// done is low; num is captured on that edge. done pulses for one cycle when
// result/ovf become valid; busy is high from the accept edge until that done edge.
interface factorial_seq_if
    import factorial_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic             start;
    logic [IN_W-1:0]  num;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] result;
    logic             ovf;
    state_t           state;

    modport master (
        output start, num,
        input  busy, done, result, ovf, state
    );

    modport slave (
        input  start, num,
        output busy, done, result, ovf, state
    );
endinterface

// File: rtl/factorial_mul.sv
// Combinational acc*i step: full-width product, truncated accumulator value
// and a flag for any bits lost above OUT_W.
module factorial_mul #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] prod,
    output logic             ovf
);
    logic [OUT_W+IN_W-1:0] full;

    assign full = {{IN_W{1'b0}}, acc} * {{OUT_W{1'b0}}, i};
    assign prod = full[OUT_W-1:0];
    assign ovf  = |full[OUT_W+IN_W-1:OUT_W];
endmodule

// File: rtl/factorial_seq.sv
// Iterative n! engine: one multiply per cycle, result/ovf held between runs.
// Define FACTORIAL_SAT_EN to saturate and exit early on the first overflow.
module factorial_seq
    import factorial_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic           clk,
    input  logic           rst,
    factorial_seq_if.slave bus
);
    state_t           state, state_nxt;
    logic [IN_W-1:0]  n, n_nxt;
    logic [IN_W-1:0]  i, i_nxt;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic             ovf_trk, ovf_trk_nxt;
    logic [OUT_W-1:0] result_q, result_nxt;
    logic             ovf_q, ovf_nxt;
    logic             done_q, done_nxt;
    logic [OUT_W-1:0] mul_prod;
    logic             mul_ovf;

    factorial_mul #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mul (
        .acc  (acc),
        .i    (i),
        .prod (mul_prod),
        .ovf  (mul_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n        <= '0;
            i        <= IN_W'(2);
            acc      <= OUT_W'(1);
            ovf_trk  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            n        <= n_nxt;
            i        <= i_nxt;
            acc      <= acc_nxt;
            ovf_trk  <= ovf_trk_nxt;
            result_q <= result_nxt;
            ovf_q    <= ovf_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        n_nxt       = n;
        i_nxt       = i;
        acc_nxt     = acc;
        ovf_trk_nxt = ovf_trk;
        result_nxt  = result_q;
        ovf_nxt     = ovf_q;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A start overlapping the done pulse is dropped on purpose.
                if (bus.start && !done_q) begin
                    n_nxt       = bus.num;
                    acc_nxt     = OUT_W'(1);
                    i_nxt       = IN_W'(2);
                    ovf_trk_nxt = 1'b0;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (n < IN_W'(2)) begin
                    result_nxt = OUT_W'(1);
                    ovf_nxt    = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    acc_nxt     = mul_prod;
                    i_nxt       = i + IN_W'(1);
                    ovf_trk_nxt = ovf_trk | mul_ovf;
`ifdef FACTORIAL_SAT_EN
                    if (mul_ovf) begin
                        result_nxt = '1;
                        ovf_nxt    = 1'b1;
                        done_nxt   = 1'b1;
                        state_nxt  = IDLE;
                    end else if (i == n) begin
                        result_nxt = mul_prod;
                        ovf_nxt    = ovf_trk;
                        done_nxt   = 1'b1;
                        state_nxt  = IDLE;
                    end
`else
                    if (i == n) begin
                        result_nxt = mul_prod;
                        ovf_nxt    = ovf_trk | mul_ovf;
                        done_nxt   = 1'b1;
                        state_nxt  = IDLE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.state  = state;
endmodule
